// File: rtl/sram_ctrl_pkg.sv
// Shared types, constants and helpers for the 1R1W SRAM client controller.
package sram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_ctrl_state_t;

  // Response buffering and fixed macro read latency.
  localparam int RSP_FIFO_DEPTH = 3;
  localparam int SRAM_RD_LAT    = 2;

  // Widest data word the mask helper can expand.
  localparam int MASK_MAX_BITS  = 256;

  // Expands a per-lane enable mask into a per-bit mask (lane i covers bits
  // i*byte_w .. i*byte_w+byte_w-1). Callers zero-extend in and truncate out.
  function automatic logic [MASK_MAX_BITS-1:0] expand_mask(
    input logic [MASK_MAX_BITS-1:0] lane_mask,
    input int unsigned              byte_w
  );
    logic [MASK_MAX_BITS-1:0] bits;
    logic [MASK_MAX_BITS-1:0] shifted;
    bits = '0;
    for (int i = 0; i < MASK_MAX_BITS; i++) begin
      shifted = lane_mask >> (i / byte_w);
      bits[i] = shifted[0];
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small in-order response buffer holding read data until the client takes it.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = RSP_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= bump(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= bump(rd_ptr_q);
      if (push_i && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!push_i && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_1r1w_ctrl.sv
// Initiator-side controller for the 1R1W SRAM macro wrappers: zero-fills the
// macro after reset, then serves valid/ready writes and reads, hiding the
// 2-cycle macro read latency and forwarding same-cycle same-address writes.
module sram_1r1w_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BYTE       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    init_done,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WIDTH/BYTE-1:0]   wr_mask,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [WIDTH/BYTE-1:0]   ram_wen,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic [WIDTH-1:0]        ram_wdata,
  output logic                    ram_ren,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  input  logic [WIDTH-1:0]        ram_rdata
);

  localparam int NB    = WIDTH / BYTE;
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  sram_ctrl_state_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;

  logic                  run, wr_fire, rd_fire, collide, deq;
  logic [CNT_W-1:0]      fifo_count;
  logic [2:0]            occupancy;

  // Read pipe: stage 1 is the cycle after issue, stage 2 lines up with ram_rdata.
  logic                  s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0]      s1_fwd_data_q, s2_fwd_data_q;
  logic [NB-1:0]         s1_fwd_mask_q, s2_fwd_mask_q;
  logic [WIDTH-1:0]      fwd_bits, merged;

  assign run       = (state_q == RUN);
  assign init_done = run;
  assign wr_ready  = run;
  assign wr_fire   = wr_valid && wr_ready;
  assign deq       = rsp_valid && rsp_ready;
  assign rsp_valid = (fifo_count != '0);

  // Reads in the pipe plus buffered responses, net of this cycle's pop, must
  // leave room in the FIFO for the new request when it returns.
  assign occupancy = 3'(s1_valid_q) + 3'(s2_valid_q) + 3'(fifo_count) - 3'(deq);
  assign rd_ready  = run && (occupancy < 3'(RSP_FIFO_DEPTH));
  assign rd_fire   = rd_valid && rd_ready;
  assign collide   = wr_fire && rd_fire && (wr_addr == rd_addr);

  // State register and zero-fill sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Sweep every address once, then settle in RUN until the next reset.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + ADDR_WIDTH'(1);
        if (sweep_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = RUN;
          sweep_d = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
  end

  // Macro port drive; held quiet while reset is asserted.
  always_comb begin
    ram_wen   = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_ren   = 1'b0;
    ram_raddr = '0;
    if (rst_n) begin
      if (!run) begin
        ram_wen   = '1;
        ram_waddr = sweep_q;
      end else if (wr_fire) begin
        ram_wen   = wr_mask;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
      end
      if (rd_fire) begin
        ram_ren   = 1'b1;
        ram_raddr = rd_addr;
      end
    end
  end

  // Read pipe carries only same-cycle forwarded lanes; later writes never touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_fwd_data_q <= '0;
      s1_fwd_mask_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_fwd_data_q <= '0;
      s2_fwd_mask_q <= '0;
    end else begin
      s1_valid_q    <= rd_fire;
      s1_fwd_data_q <= collide ? wr_data : '0;
      s1_fwd_mask_q <= collide ? wr_mask : '0;
      s2_valid_q    <= s1_valid_q;
      s2_fwd_data_q <= s1_fwd_data_q;
      s2_fwd_mask_q <= s1_fwd_mask_q;
    end
  end

  assign fwd_bits = WIDTH'(expand_mask(MASK_MAX_BITS'(s2_fwd_mask_q), BYTE));
  assign merged   = (s2_fwd_data_q & fwd_bits) | (ram_rdata & ~fwd_bits);

  sram_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (s2_valid_q),
    .push_data_i (merged),
    .pop_i       (deq),
    .count_o     (fifo_count),
    .head_o      (rsp_data)
  );

endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// Self-checking bench for sram_1r1w_ctrl with a behavioural 2-cycle macro.
module tb_sram_1r1w_ctrl;

  localparam int W  = 32;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int NB = 4;

  logic          clk;
  logic          rst_n;
  logic          init_done;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_mask;
  logic [W-1:0]  wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [NB-1:0] ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [W-1:0]  ram_wdata;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic [W-1:0]  ram_rdata;

  logic [W-1:0]  macroMem [D];
  logic [W-1:0]  macroStage;
  logic [W-1:0]  modelMem [D];
  logic [W-1:0]  expQ [$];

  int            nChecks = 0;
  int            nErrors = 0;
  logic          wrFireS, rdFireS, rdReadyS, rspValidS;

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [NB-1:0] wm;
    logic [W-1:0]  wd;
    logic          rv;
    logic [AW-1:0] ra;
    logic [W-1:0]  expD;
  } vec_t;

  vec_t vecs [16];

  sram_1r1w_ctrl #(
    .WIDTH      (W),
    .DEPTH      (D),
    .ADDR_WIDTH (AW),
    .BYTE       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: read-first, data visible two cycles after the enable.
  always @(posedge clk) begin
    for (int l = 0; l < NB; l++)
      if (ram_wen[l]) macroMem[ram_waddr][l*8 +: 8] <= ram_wdata[l*8 +: 8];
    if (ram_ren) macroStage <= macroMem[ram_raddr];
    ram_rdata <= macroStage;
  end

  // Hard stop in case something hangs.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // One cycle: drive at the falling edge, sample mid-cycle, run the scoreboard.
  task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [NB-1:0] wm,
                               input logic [W-1:0] wd, input logic rv, input logic [AW-1:0] ra,
                               input logic rr, input logic useExp, input logic [W-1:0] expD);
    logic [W-1:0] e;
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_mask = wm; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rsp_ready = rr;
    #2;
    wrFireS   = wr_valid && wr_ready;
    rdFireS   = rd_valid && rd_ready;
    rdReadyS  = rd_ready;
    rspValidS = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL rsp_spurious: got 0x%08h, want no response", rsp_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_data", rsp_data, e);
      end
    end
    if (wrFireS) begin
      checkOutput("ram_wen", 32'(ram_wen), 32'(wm));
      for (int l = 0; l < NB; l++)
        if (wm[l]) modelMem[wa][l*8 +: 8] = wd[l*8 +: 8];
    end
    if (rdFireS) begin
      checkOutput("ram_raddr", 32'(ram_raddr), 32'(ra));
      expQ.push_back(useExp ? expD : modelMem[ra]);
    end
  endtask

  task automatic idleCycle(input logic rr);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, rr, 1'b0, '0);
  endtask

  task automatic drain(input int n);
    repeat (n) idleCycle(1'b1);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  // Called right after reset release at a falling edge; follows the sweep.
  task automatic waitInit();
    int k;
    int spurious;
    k = 0;
    spurious = 0;
    #2;
    checkOutput("init_waddr0", 32'(ram_waddr), 32'd0);
    checkOutput("init_wen", 32'(ram_wen), 32'hF);
    checkOutput("init_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("init_rd_ready", 32'(rd_ready), 32'd0);
    while (!init_done && k < 200) begin
      @(negedge clk);
      #2;
      k++;
      if (rsp_valid) spurious++;
      if (k == 10) checkOutput("init_waddr10", 32'(ram_waddr), 32'd10);
    end
    checkOutput("init_cycles", 32'(k), 32'd64);
    checkOutput("init_no_rsp", 32'(spurious), 32'd0);
    for (int a = 0; a < D; a++) modelMem[a] = '0;
  endtask

  initial begin
    int idx;
    int lat;
    logic seen;

    // Table of single-cycle operations with hand-derived read results.
    vecs[0]  = '{1'b1, 6'd5,  4'hF, 32'hDEADBEEF, 1'b0, 6'd0,  32'h0};
    vecs[1]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b0, 6'd0,  32'h0};
    vecs[2]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd5,  32'hDEADBEEF};
    vecs[3]  = '{1'b1, 6'd9,  4'hF, 32'h11223344, 1'b0, 6'd0,  32'h0};
    vecs[4]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b0, 6'd0,  32'h0};
    vecs[5]  = '{1'b1, 6'd9,  4'h5, 32'hAABBCCDD, 1'b1, 6'd9,  32'h11BB33DD};
    vecs[6]  = '{1'b1, 6'd7,  4'hF, 32'h0BADF00D, 1'b0, 6'd0,  32'h0};
    vecs[7]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b0, 6'd0,  32'h0};
    vecs[8]  = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd7,  32'h0BADF00D};
    vecs[9]  = '{1'b1, 6'd7,  4'hF, 32'h12345678, 1'b0, 6'd0,  32'h0};
    vecs[10] = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd7,  32'h12345678};
    vecs[11] = '{1'b1, 6'd63, 4'h8, 32'hCAFE0000, 1'b1, 6'd63, 32'hCA000000};
    vecs[12] = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd0,  32'h0};
    vecs[13] = '{1'b1, 6'd20, 4'h0, 32'hFFFFFFFF, 1'b1, 6'd20, 32'h0};
    vecs[14] = '{1'b1, 6'd21, 4'h3, 32'h77775A5A, 1'b0, 6'd0,  32'h0};
    vecs[15] = '{1'b0, 6'd0,  4'h0, 32'h0,        1'b1, 6'd21, 32'h00005A5A};

    for (int a = 0; a < D; a++) begin
      macroMem[a] = 32'hA5A5A5A5 ^ 32'(a);
      modelMem[a] = '0;
    end
    macroStage = '0;
    ram_rdata  = '0;
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_rd_ready", 32'(rd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_ram_wen", 32'(ram_wen), 32'd0);
    checkOutput("rst_ram_ren", 32'(ram_ren), 32'd0);
    checkOutput("rst_ram_waddr", 32'(ram_waddr), 32'd0);
    checkOutput("rst_ram_raddr", 32'(ram_raddr), 32'd0);
    checkOutput("rst_ram_wdata", ram_wdata, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    waitInit();

    // Zero-fill: every address reads back as zero.
    for (int a = 0; a < D; a++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1, 1'b0, '0);
    drain(6);

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].wv, vecs[i].wa, vecs[i].wm, vecs[i].wd,
                    vecs[i].rv, vecs[i].ra, 1'b1, 1'b1, vecs[i].expD);
      checkOutput("tbl_rd_fire", 32'(rdFireS), 32'(vecs[i].rv));
    end
    drain(6);

    // Read latency: response appears three cycles after the read fire.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b1, 1'b0, '0);
    checkOutput("lat_rd_fire", 32'(rdFireS), 32'd1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      idleCycle(1'b1);
      lat++;
      if (rspValidS) seen = 1'b1;
    end
    checkOutput("rsp_latency", 32'(lat), 32'd3);
    drain(4);

    // Backpressure: only three reads admitted while responses are blocked.
    for (int a = 0; a < 5; a++)
      applyStimulus(1'b1, AW'(30 + a), 4'hF, 32'h30303030 + 32'(a * 32'h01010101), 1'b0, '0, 1'b1, 1'b0, '0);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(30 + idx), 1'b0, 1'b0, '0);
      if (rdFireS) idx++;
    end
    checkOutput("bp_accepted", 32'(idx), 32'd3);
    checkOutput("bp_rd_ready_low", 32'(rdReadyS), 32'd0);
    checkOutput("bp_rsp_valid", 32'(rspValidS), 32'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(30 + idx), 1'b1, 1'b0, '0);
    checkOutput("bp_rd_ready_recover", 32'(rdReadyS), 32'd1);
    if (rdFireS) idx++;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(30 + idx), 1'b1, 1'b0, '0);
      if (rdFireS) idx++;
    end
    checkOutput("bp_all_accepted", 32'(idx), 32'd5);
    drain(8);

    // Reset with two reads in the pipe and one response buffered.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd9, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd7, 1'b0, 1'b0, '0);
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    checkOutput("mid_rsp_before", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rsp_drop", 32'(rsp_valid), 32'd0);
    checkOutput("mid_ram_wen", 32'(ram_wen), 32'd0);
    checkOutput("mid_init_done", 32'(init_done), 32'd0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitInit();

    // Earlier data is gone after the fresh sweep.
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd9, 1'b1, 1'b0, '0);
    drain(6);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
